// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR sequencer: FSM state encoding,
// datapath geometry and the tap-count normalization helper.
package fir_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } fir_state_t;

   localparam int FIR_SIZE   = 64;
   localparam int FIR_ADDR_W = 6;
   localparam int FIR_DATA_W = 16;

   // A request of 0 taps, or more taps than the register holds, means "all taps".
   function automatic int norm_taps(input int taps, input int size);
      return (taps == 0 || taps > size) ? size : taps;
   endfunction

endpackage

// File: rtl/tap_counter.sv
// Tap index counter with synchronous clear/enable and a terminal-count flag
// that compares against the latched tap count.
module tap_counter
   import fir_pkg::*;
#(
   parameter int ADDR_W = FIR_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   input  logic [ADDR_W:0]   ntaps,
   output logic [ADDR_W:0]   count,
   output logic              last
);

   // One extra bit so a full-depth sweep never wraps back to zero.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + (ADDR_W+1)'(1);
      end
   end

   assign last = (count == (ntaps - (ADDR_W+1)'(1)));

endmodule

// File: rtl/fir_seq_ctrl.sv
// FIR sequencer: accepts one sample per handshake, pulses the shift register,
// sweeps tap addresses while strobing the MAC, then holds result-valid.
module fir_seq_ctrl
   import fir_pkg::*;
#(
   parameter int SIZE   = FIR_SIZE,
   parameter int ADDR_W = FIR_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [ADDR_W:0]   taps_cfg,
   output logic              sr_shift,
   output logic [ADDR_W-1:0] sr_addr,
   output logic [ADDR_W-1:0] coef_addr,
   output logic              mac_first,
   output logic              mac_en,
   output logic              mac_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output fir_state_t        dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid and ready are
   // both high; valid never waits on ready, and ready is decoded from state only.

   fir_state_t        state, state_n;
   logic [ADDR_W:0]   ntaps;
   logic [ADDR_W:0]   taps_norm;
   logic [ADDR_W:0]   count;
   logic              last;
   logic              cnt_clr;
   logic              cnt_en;
   logic              accum;

   assign taps_norm = (ADDR_W+1)'(norm_taps(int'(taps_cfg), SIZE));

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Tap count is captured only on the accepting edge; later taps_cfg changes are ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         ntaps <= (ADDR_W+1)'(SIZE);
      end else if (sr_shift) begin
         ntaps <= taps_norm;
      end
   end

   always_comb begin
      state_n = state;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               state_n = ACCUM;
               cnt_clr = 1'b1;
            end
         end
         ACCUM: begin
            if (last) begin
               state_n = DONE;
            end else begin
               cnt_en = 1'b1;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   tap_counter #(.ADDR_W(ADDR_W)) u_tap_counter (
      .clk   (clk),
      .rst   (rst),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .ntaps (ntaps),
      .count (count),
      .last  (last)
   );

   assign accum     = (state == ACCUM);
   assign in_ready  = (state == IDLE);
   assign busy      = (state != IDLE);
   assign sr_shift  = in_valid & in_ready;
   assign out_valid = (state == DONE);
   assign sr_addr   = accum ? count[ADDR_W-1:0] : '0;
   assign coef_addr = sr_addr;
   assign mac_en    = accum;
   assign mac_first = accum && (count == '0);
   assign mac_last  = accum && last;
   assign dbg_state = state;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed bench for fir_seq_ctrl: a vector table for short transactions plus
// hand-written sequences for full-length sweeps, backpressure and mid-run reset.
module tb_fir_seq_ctrl;
   import fir_pkg::*;

   localparam int AW = 6;
   localparam int OW = 19;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [AW:0]   taps_cfg;
   logic          sr_shift;
   logic [AW-1:0] sr_addr;
   logic [AW-1:0] coef_addr;
   logic          mac_first;
   logic          mac_en;
   logic          mac_last;
   logic          out_valid;
   logic          out_ready;
   logic          busy;
   fir_state_t    dbg_state;
   logic [15:0]   din;

   int n_checks = 0;
   int n_fail   = 0;
   logic [AW-1:0] exp_q[$];

   typedef struct {
      bit          r;
      bit          iv;
      logic [AW:0] taps;
      bit          ordy;
      logic [OW-1:0] exp;
   } vec_t;

   vec_t tbl[17];

   // clock / reset
   always #5 clk = ~clk;

   fir_seq_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .taps_cfg  (taps_cfg),
      .sr_shift  (sr_shift),
      .sr_addr   (sr_addr),
      .coef_addr (coef_addr),
      .mac_first (mac_first),
      .mac_en    (mac_en),
      .mac_last  (mac_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   wire [OW-1:0] obs = {in_ready, sr_shift, busy, out_valid,
                        mac_first, mac_en, mac_last, sr_addr, coef_addr};

   function automatic logic [OW-1:0] mk(input bit ir, input bit sh, input bit bz,
                                         input bit ov, input bit mf, input bit me,
                                         input bit ml, input logic [AW-1:0] a);
      return {ir, sh, bz, ov, mf, me, ml, a, a};
   endfunction

   function automatic logic [OW-1:0] idle_e(input bit sh);
      return mk(1'b1, sh, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
   endfunction

   function automatic logic [OW-1:0] acc_e(input bit mf, input bit ml, input logic [AW-1:0] a);
      return mk(1'b0, 1'b0, 1'b1, 1'b0, mf, 1'b1, ml, a);
   endfunction

   function automatic logic [OW-1:0] done_e();
      return mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
   endfunction

   // driver + scoreboard compare: drive just after the rising edge, check at the falling edge
   task automatic cyc(input string name, input bit r, input bit iv, input logic [AW:0] t,
                      input bit ordy, input bit chk, input logic [OW-1:0] exp);
      @(posedge clk);
      #1;
      rst       = r;
      in_valid  = iv;
      taps_cfg  = t;
      out_ready = ordy;
      din       = 16'($urandom_range(0, 65535));
      @(negedge clk);
      if (chk) begin
         n_checks++;
         if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (ir,sh,busy,ov,mf,me,ml,addr,coef)",
                     name, obs, exp);
         end
      end
   endtask

   task automatic run_full(input string name, input logic [AW:0] cfg);
      for (int i = 0; i < 64; i++) exp_q.push_back(AW'(i));
      cyc(name, 1'b0, 1'b1, cfg, 1'b1, 1'b1, idle_e(1'b1));
      for (int i = 0; i < 64; i++) begin
         logic [AW-1:0] a;
         a = exp_q.pop_front();
         cyc(name, 1'b0, 1'b0, 7'd5, 1'b1, 1'b1, acc_e(i == 0, i == 63, a));
      end
      cyc(name, 1'b0, 1'b0, 7'd5, 1'b1, 1'b1, done_e());
      cyc(name, 1'b0, 1'b0, 7'd5, 1'b1, 1'b1, idle_e(1'b0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; taps_cfg = '0; out_ready = 1'b1; din = '0;

      tbl[0]  = '{1'b0, 1'b0, 7'd0, 1'b1, idle_e(1'b0)};
      tbl[1]  = '{1'b0, 1'b1, 7'd4, 1'b1, idle_e(1'b1)};
      tbl[2]  = '{1'b0, 1'b0, 7'd9, 1'b1, acc_e(1'b1, 1'b0, 6'd0)};
      tbl[3]  = '{1'b0, 1'b1, 7'd9, 1'b1, acc_e(1'b0, 1'b0, 6'd1)};
      tbl[4]  = '{1'b0, 1'b0, 7'd9, 1'b1, acc_e(1'b0, 1'b0, 6'd2)};
      tbl[5]  = '{1'b0, 1'b0, 7'd9, 1'b1, acc_e(1'b0, 1'b1, 6'd3)};
      tbl[6]  = '{1'b0, 1'b0, 7'd9, 1'b1, done_e()};
      tbl[7]  = '{1'b0, 1'b0, 7'd9, 1'b1, idle_e(1'b0)};
      tbl[8]  = '{1'b0, 1'b1, 7'd1, 1'b1, idle_e(1'b1)};
      tbl[9]  = '{1'b0, 1'b0, 7'd1, 1'b1, acc_e(1'b1, 1'b1, 6'd0)};
      tbl[10] = '{1'b0, 1'b0, 7'd1, 1'b0, done_e()};
      tbl[11] = '{1'b0, 1'b1, 7'd2, 1'b1, done_e()};
      tbl[12] = '{1'b0, 1'b1, 7'd2, 1'b1, idle_e(1'b1)};
      tbl[13] = '{1'b0, 1'b0, 7'd2, 1'b1, acc_e(1'b1, 1'b0, 6'd0)};
      tbl[14] = '{1'b0, 1'b0, 7'd2, 1'b1, acc_e(1'b0, 1'b1, 6'd1)};
      tbl[15] = '{1'b0, 1'b0, 7'd2, 1'b1, done_e()};
      tbl[16] = '{1'b0, 1'b0, 7'd2, 1'b1, idle_e(1'b0)};

      cyc("reset", 1'b1, 1'b0, 7'd0, 1'b1, 1'b0, '0);
      cyc("reset", 1'b1, 1'b0, 7'd0, 1'b1, 1'b0, '0);

      for (int i = 0; i < 17; i++) begin
         cyc($sformatf("vec%0d", i), tbl[i].r, tbl[i].iv, tbl[i].taps, tbl[i].ordy,
             1'b1, tbl[i].exp);
      end

      run_full("full_cfg0", 7'd0);
      run_full("full_cfg70", 7'd70);

      // backpressure: result held, offered sample refused until back in IDLE
      cyc("bp_hs", 1'b0, 1'b1, 7'd3, 1'b1, 1'b1, idle_e(1'b1));
      for (int i = 0; i < 3; i++)
         cyc("bp_acc", 1'b0, 1'b0, 7'd3, 1'b1, 1'b1, acc_e(i == 0, i == 2, AW'(i)));
      for (int i = 0; i < 5; i++) begin
         cyc("bp_hold", 1'b0, 1'b1, 7'd1, 1'b0, 1'b0, '0);
         n_checks++;
         if (obs !== done_e() || din !== 16'hFFFF && 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold: got %h expected %h", obs, done_e());
         end
      end
      cyc("bp_release", 1'b0, 1'b1, 7'd1, 1'b1, 1'b1, done_e());
      cyc("bp_accept", 1'b0, 1'b1, 7'd1, 1'b1, 1'b1, idle_e(1'b1));
      cyc("bp_acc1", 1'b0, 1'b0, 7'd1, 1'b1, 1'b1, acc_e(1'b1, 1'b1, 6'd0));
      cyc("bp_done", 1'b0, 1'b0, 7'd1, 1'b1, 1'b1, done_e());
      cyc("bp_idle", 1'b0, 1'b0, 7'd1, 1'b1, 1'b1, idle_e(1'b0));

      // reset while sweeping: address 10 is the last ACCUM cycle seen
      cyc("rm_hs", 1'b0, 1'b1, 7'd0, 1'b1, 1'b1, idle_e(1'b1));
      for (int i = 0; i < 10; i++)
         cyc("rm_acc", 1'b0, 1'b0, 7'd0, 1'b1, 1'b1, acc_e(i == 0, 1'b0, AW'(i)));
      cyc("rm_rst", 1'b1, 1'b0, 7'd0, 1'b1, 1'b1, acc_e(1'b0, 1'b0, 6'd10));
      cyc("rm_idle", 1'b0, 1'b0, 7'd0, 1'b1, 1'b1, idle_e(1'b0));
      cyc("rm_idle2", 1'b0, 1'b0, 7'd0, 1'b1, 1'b1, idle_e(1'b0));
      cyc("rm_hs2", 1'b0, 1'b1, 7'd2, 1'b1, 1'b1, idle_e(1'b1));
      cyc("rm_acc0", 1'b0, 1'b0, 7'd2, 1'b1, 1'b1, acc_e(1'b1, 1'b0, 6'd0));
      cyc("rm_acc1", 1'b0, 1'b0, 7'd2, 1'b1, 1'b1, acc_e(1'b0, 1'b1, 6'd1));
      cyc("rm_done", 1'b0, 1'b0, 7'd2, 1'b1, 1'b1, done_e());
      cyc("rm_end", 1'b0, 1'b0, 7'd2, 1'b1, 1'b1, idle_e(1'b0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
